// File: rtl/prod_accumulator_pkg.sv
// Shared types and constants for the product accumulator: FSM state encoding,
// product width and default parameter values.
package prod_accumulator_pkg;

  localparam int PROD_W    = 16;
  localparam int ACC_W_DEF = 18;
  localparam int LEN_W_DEF = 4;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    ACC  = 2'd1,
    HOLD = 2'd2
  } state_e;

endpackage

// File: rtl/prod_accumulator_sat.sv
// Combinational two's-complement saturating adder: clamps to the most positive
// or most negative W-bit value and flags when clamping happened.
module sat_add #(
  parameter int W = 18
) (
  input  logic [W-1:0] a_i,
  input  logic [W-1:0] b_i,
  output logic [W-1:0] sum_o,
  output logic         sat_o
);

  localparam logic [W-1:0] MAX_POS = {1'b0, {(W-1){1'b1}}};
  localparam logic [W-1:0] MAX_NEG = {1'b1, {(W-1){1'b0}}};

  logic [W:0] full;

  // One guard bit: overflow iff the guard bit and the result sign disagree.
  assign full  = {a_i[W-1], a_i} + {b_i[W-1], b_i};
  assign sat_o = full[W] ^ full[W-1];

  always_comb begin
    sum_o = full[W-1:0];
    if (sat_o) begin
      sum_o = full[W] ? MAX_NEG : MAX_POS;
    end
  end

endmodule

// File: rtl/prod_accumulator.sv
// Frame accumulator: sums a programmed number of signed products with
// saturation, then holds the result until the consumer takes it.
module prod_accumulator
  import prod_accumulator_pkg::*;
#(
  parameter int ACC_W = ACC_W_DEF,
  parameter int LEN_W = LEN_W_DEF
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              start,
  input  logic [LEN_W-1:0]  len,
  input  logic              clr,
  input  logic              in_valid,
  output logic              in_ready,
  input  logic [PROD_W-1:0] in_prod,
  output logic              out_valid,
  input  logic              out_ready,
  output logic [ACC_W-1:0]  out_sum,
  output logic              out_ovf,
  output logic              busy
);

  localparam logic [LEN_W:0] CNT_ONE  = (LEN_W + 1)'(1);
  localparam logic [LEN_W:0] CNT_FULL = {1'b1, {LEN_W{1'b0}}};

  state_e           state_q;
  logic [LEN_W:0]   count_q;
  logic [ACC_W-1:0] acc_q;
  logic             ovf_q;
  logic             out_valid_q;
  logic [ACC_W-1:0] out_sum_q;
  logic             out_ovf_q;

  logic [ACC_W-1:0] prod_ext;
  logic [ACC_W-1:0] sum_d;
  logic             sat_d;
  logic             ovf_d;

  assign prod_ext = {{(ACC_W - PROD_W){in_prod[PROD_W-1]}}, in_prod};
  assign ovf_d    = ovf_q | sat_d;

  sat_add #(
    .W (ACC_W)
  ) u_sat_add (
    .a_i   (acc_q),
    .b_i   (prod_ext),
    .sum_o (sum_d),
    .sat_o (sat_d)
  );

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q     <= IDLE;
      count_q     <= '0;
      acc_q       <= '0;
      ovf_q       <= 1'b0;
      out_valid_q <= 1'b0;
      out_sum_q   <= '0;
      out_ovf_q   <= 1'b0;
    end else if (clr) begin
      state_q     <= IDLE;
      out_valid_q <= 1'b0;
    end else begin
      case (state_q)
        IDLE: begin
          if (start) begin
            count_q <= (len == '0) ? CNT_FULL : {1'b0, len};
            acc_q   <= '0;
            ovf_q   <= 1'b0;
            state_q <= ACC;
          end
        end
        ACC: begin
          if (in_valid) begin
            acc_q   <= sum_d;
            ovf_q   <= ovf_d;
            count_q <= count_q - CNT_ONE;
            // Last product: publish the post-add value directly so the
            // result is visible one cycle after the final accept.
            if (count_q == CNT_ONE) begin
              state_q     <= HOLD;
              out_valid_q <= 1'b1;
              out_sum_q   <= sum_d;
              out_ovf_q   <= ovf_d;
            end
          end
        end
        HOLD: begin
          if (out_ready) begin
            state_q     <= IDLE;
            out_valid_q <= 1'b0;
          end
        end
        default: begin
          state_q     <= IDLE;
          out_valid_q <= 1'b0;
        end
      endcase
    end
  end

  assign in_ready  = (state_q == ACC);
  assign busy      = (state_q != IDLE);
  assign out_valid = out_valid_q;
  assign out_sum   = out_sum_q;
  assign out_ovf   = out_ovf_q;

endmodule

// File: tb/tb_prod_accumulator.sv
// Directed bench for prod_accumulator: a table of whole frames plus
// hand-written sequences for back-pressure, reset, clear and ignored inputs.
module tb_prod_accumulator;

  localparam int ACC_W = 18;
  localparam int LEN_W = 4;

  logic             clk = 1'b0;
  logic             rst = 1'b1;
  logic             start = 1'b0;
  logic [LEN_W-1:0] len = '0;
  logic             clr = 1'b0;
  logic             in_valid = 1'b0;
  logic             in_ready;
  logic [15:0]      in_prod = '0;
  logic             out_valid;
  logic             out_ready = 1'b0;
  logic [ACC_W-1:0] out_sum;
  logic             out_ovf;
  logic             busy;

  int n_checks = 0;
  int n_fail   = 0;

  prod_accumulator #(
    .ACC_W (ACC_W),
    .LEN_W (LEN_W)
  ) dut (
    .clk       (clk),
    .rst       (rst),
    .start     (start),
    .len       (len),
    .clr       (clr),
    .in_valid  (in_valid),
    .in_ready  (in_ready),
    .in_prod   (in_prod),
    .out_valid (out_valid),
    .out_ready (out_ready),
    .out_sum   (out_sum),
    .out_ovf   (out_ovf),
    .busy      (busy)
  );

  always #5 clk = ~clk;

  typedef struct {
    string      name;
    logic [3:0] len;
    int         n;
    int         prod[16];
    int         exp_sum;
    bit         exp_ovf;
  } vec_t;

  vec_t vecs[6];

  task automatic check(input string name, input longint act, input longint exp);
    n_checks++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0d expected %0d", name, act, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  // Present one product and hold it until accepted (bounded wait).
  task automatic feed_one(input int p, input string name);
    int k;
    in_valid = 1'b1;
    in_prod  = 16'(p);
    for (k = 0; k < 20; k++) begin
      if (in_ready) break;
      tick();
    end
    if (k == 20) check({name, "_accept_timeout"}, 0, 1);
    tick();
    in_valid = 1'b0;
  endtask

  task automatic begin_frame(input logic [3:0] l);
    start = 1'b1;
    len   = l;
    tick();
    start = 1'b0;
  endtask

  task automatic run_frame(input vec_t v);
    begin_frame(v.len);
    check({v.name, "_busy"}, longint'(busy), 1);
    for (int i = 0; i < v.n; i++) feed_one(v.prod[i], v.name);
    check({v.name, "_valid_lat1"}, longint'(out_valid), 1);
    check({v.name, "_sum"}, longint'($signed(out_sum)), longint'(v.exp_sum));
    check({v.name, "_ovf"}, longint'(out_ovf), longint'(v.exp_ovf));
    out_ready = 1'b1;
    tick();
    out_ready = 1'b0;
    check({v.name, "_valid_drop"}, longint'(out_valid), 0);
    check({v.name, "_idle"}, longint'(busy), 0);
    $display("frame %s len=%0d n=%0d sum=%0d ovf=%0d", v.name, v.len, v.n,
             $signed(out_sum), out_ovf);
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: got timeout expected finish");
    $fatal(1, "watchdog");
  end

  initial begin
    vec_t v;

    vecs[0].name = "basic3"; vecs[0].len = 4'd3; vecs[0].n = 3;
    vecs[0].prod[0] = 6; vecs[0].prod[1] = -10; vecs[0].prod[2] = 100;
    vecs[0].exp_sum = 96; vecs[0].exp_ovf = 1'b0;

    vecs[1].name = "posfull"; vecs[1].len = 4'd0; vecs[1].n = 16;
    for (int i = 0; i < 16; i++) vecs[1].prod[i] = 16384;
    vecs[1].exp_sum = 131071; vecs[1].exp_ovf = 1'b1;

    vecs[2].name = "negfull"; vecs[2].len = 4'd0; vecs[2].n = 16;
    for (int i = 0; i < 16; i++) vecs[2].prod[i] = -16384;
    vecs[2].exp_sum = -131072; vecs[2].exp_ovf = 1'b1;

    vecs[3].name = "extremes"; vecs[3].len = 4'd2; vecs[3].n = 2;
    vecs[3].prod[0] = 32767; vecs[3].prod[1] = -32768;
    vecs[3].exp_sum = -1; vecs[3].exp_ovf = 1'b0;

    vecs[4].name = "single"; vecs[4].len = 4'd1; vecs[4].n = 1;
    vecs[4].prod[0] = -32768;
    vecs[4].exp_sum = -32768; vecs[4].exp_ovf = 1'b0;

    // Clamp at +131071 on the 5th, then continue from the clamped value.
    vecs[5].name = "clamp_resume"; vecs[5].len = 4'd6; vecs[5].n = 6;
    for (int i = 0; i < 5; i++) vecs[5].prod[i] = 32767;
    vecs[5].prod[5] = -32768;
    vecs[5].exp_sum = 98303; vecs[5].exp_ovf = 1'b1;

    // Reset state
    tick();
    check("rst_busy", longint'(busy), 0);
    check("rst_in_ready", longint'(in_ready), 0);
    check("rst_out_valid", longint'(out_valid), 0);
    check("rst_out_sum", longint'(out_sum), 0);
    check("rst_out_ovf", longint'(out_ovf), 0);
    rst = 1'b0;
    tick();

    foreach (vecs[i]) run_frame(vecs[i]);

    // Input gaps and output back-pressure
    begin_frame(4'd2);
    tick();
    feed_one(50, "bp");
    tick();
    tick();
    feed_one(70, "bp");
    check("bp_valid_lat1", longint'(out_valid), 1);
    for (int c = 0; c < 5; c++) begin
      tick();
      check("bp_hold_valid", longint'(out_valid), 1);
      check("bp_hold_sum", longint'($signed(out_sum)), 120);
      check("bp_hold_in_ready", longint'(in_ready), 0);
    end
    out_ready = 1'b1;
    start     = 1'b1;
    tick();
    out_ready = 1'b0;
    start     = 1'b0;
    check("bp_valid_drop", longint'(out_valid), 0);
    check("bp_idle", longint'(busy), 0);
    tick();
    check("bp_start_ignored", longint'(busy), 0);
    $display("frame backpressure sum=%0d", $signed(out_sum));

    // Asynchronous reset mid-frame
    begin_frame(4'd4);
    feed_one(1000, "midrst");
    feed_one(2000, "midrst");
    #2 rst = 1'b1;
    #1;
    check("midrst_busy", longint'(busy), 0);
    check("midrst_in_ready", longint'(in_ready), 0);
    check("midrst_out_valid", longint'(out_valid), 0);
    check("midrst_out_sum", longint'(out_sum), 0);
    check("midrst_out_ovf", longint'(out_ovf), 0);
    @(posedge clk);
    #1 rst = 1'b0;
    $display("reset mid-frame applied");
    v.name = "post_rst"; v.len = 4'd1; v.n = 1; v.prod[0] = -7;
    v.exp_sum = -7; v.exp_ovf = 1'b0;
    run_frame(v);

    // Clear in ACC, start in HOLD, clear in HOLD, in_valid in IDLE
    begin_frame(4'd3);
    feed_one(5, "clr");
    in_valid = 1'b1;
    in_prod  = 16'd9;
    clr      = 1'b1;
    tick();
    clr      = 1'b0;
    in_valid = 1'b0;
    check("clr_acc_busy", longint'(busy), 0);
    check("clr_acc_in_ready", longint'(in_ready), 0);
    check("clr_acc_out_valid", longint'(out_valid), 0);
    $display("clear in ACC applied");

    begin_frame(4'd1);
    feed_one(4, "hold");
    check("hold_valid", longint'(out_valid), 1);
    start = 1'b1;
    for (int c = 0; c < 2; c++) begin
      tick();
      check("hold_start_valid", longint'(out_valid), 1);
      check("hold_start_busy", longint'(busy), 1);
      check("hold_start_sum", longint'($signed(out_sum)), 4);
    end
    start = 1'b0;
    clr   = 1'b1;
    tick();
    clr   = 1'b0;
    check("clr_hold_valid", longint'(out_valid), 0);
    check("clr_hold_busy", longint'(busy), 0);
    check("clr_hold_sum_kept", longint'($signed(out_sum)), 4);
    $display("start in HOLD ignored, clear in HOLD applied");

    in_valid = 1'b1;
    in_prod  = 16'd1000;
    for (int c = 0; c < 3; c++) begin
      tick();
      check("idle_in_ready", longint'(in_ready), 0);
      check("idle_busy", longint'(busy), 0);
    end
    in_valid = 1'b0;
    $display("in_valid in IDLE ignored");
    v.name = "after_idle"; v.len = 4'd1; v.n = 1; v.prod[0] = 3;
    v.exp_sum = 3; v.exp_ovf = 1'b0;
    run_frame(v);

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
